sub_bytes_serial: RTL and testbench

Iterative forward AES SubBytes engine for the encrypt datapath. It is the counterpart of the combinational inverse-substitution stage.
- Accepts one 128-bit state over a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through a small bank of shared forward sbox instances.
- Returns the result over a second valid/ready handshake.
- Trades latency for area relative to a 16-sbox combinational stage.

---
 rtl/sub_bytes_serial.sv | 137 +++++++++++++
 tb/tb_sub_bytes_serial.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_serial.sv
// sub_bytes_serial: iterative forward AES SubBytes engine.
// Takes one 128-bit state per valid/ready handshake and substitutes
// BYTES_PER_CYCLE bytes per clock through a bank of shared forward S-boxes.
// The finished block is returned over a second valid/ready handshake.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   in_valid   in_data valid
//   in_ready   engine idle and able to accept a block
//   in_data    state; byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  out_data holds a completed result
//   out_ready  downstream accepts out_data
//   out_data   SubBytes(in_data), same byte ordering
//   busy       high while processing or holding a result
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// BUSY  | substituting BYTES_PER_CYCLE bytes per edge
// DONE  | result valid, waiting for out_ready

module sbox_fwd (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [7:0] TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s = TABLE[a];
endmodule

module sub_bytes_serial #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int BPC     = BYTES_PER_CYCLE;
  localparam int NB      = 16 / BPC;
  localparam int CW      = (NB > 1) ? $clog2(NB) : 1;
  localparam int LOG_BPC = $clog2(BPC);

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
    $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [127:0]    work, work_next;
  logic [3:0]      base;
  logic            last;
  logic [7:0]      lane_in  [BPC];
  logic [7:0]      lane_out [BPC];

  // First byte handled this cycle; BPC is a power of two so this is a shift.
  assign base = 4'(4'(cnt) << LOG_BPC);
  assign last = (cnt == CW'(NB - 1));

  for (genvar l = 0; l < BPC; l++) begin : g_lane
    assign lane_in[l] = work[127 - 8 * (int'(base) + l) -: 8];
    sbox_fwd u_sbox (.a(lane_in[l]), .s(lane_out[l]));
  end

  always_comb begin
    work_next = work;
    for (int l = 0; l < BPC; l++) begin
      work_next[127 - 8 * (int'(base) + l) -: 8] = lane_out[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      work <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_data;
          cnt  <= '0;
        end
        BUSY: begin
          work <= work_next;
          // Hold at NB-1 on the final edge; the next accept clears it.
          if (!last) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by rst so it reads 0 throughout reset.
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

endmodule

// File: tb/tb_sub_bytes_serial.sv
module tb_sub_bytes_serial;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, out_ready;
  logic [127:0] in_data;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;

  // parameter-sweep instances share clk/rst and a separate handshake
  localparam int SW [4] = '{1, 2, 8, 16};
  logic         sw_valid, sw_ready;
  logic [3:0]   sw_in_ready, sw_out_valid, sw_busy;
  logic [127:0] sw_out_data [4];

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_tab [256];

  always #5 clk = ~clk;

  sub_bytes_serial #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    sub_bytes_serial #(.BYTES_PER_CYCLE(SW[g])) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_in_ready[g]),
      .in_data(in_data), .out_valid(sw_out_valid[g]), .out_ready(sw_ready),
      .out_data(sw_out_data[g]), .busy(sw_busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box from GF(2^8) inverse plus the affine transform.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    end
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = ref_tab[d[127 - 8 * i -: 8]];
    return r;
  endfunction

  task automatic send(input logic [127:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_timeout", 128'(n < 100), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] held, d, a, b;
    int lat, seen, stall;
    int sw_lat [4];

    for (int i = 0; i < 256; i++) ref_tab[i] = sbox_calc(8'(i));

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    sw_valid = 1'b0; sw_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // FIPS-197 round-1 SubBytes vector, latency 4
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    check("busy_high", busy, 1);
    wait_out(lat);
    check("b_vec_latency", lat, 4);
    check("b_vec_data", out_data, 128'hd42711aee0bf98f1b8b45de51e415230);
    take();

    // corner bytes
    send('0);           wait_out(lat); check("zeros", out_data, {16{8'h63}}); take();
    send({16{8'hff}});  wait_out(lat); check("ones",  out_data, {16{8'h16}}); take();
    send({16{8'h01}});  wait_out(lat); check("x01",   out_data, {16{8'h7c}}); take();

    // backpressure
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d);
    wait_out(lat);
    held = sub_ref(d);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_data_stable", out_data, held);
      check("bp_valid_held", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    take();
    check("bp_valid_drop", out_valid, 0);
    check("bp_in_ready_rise", in_ready, 1);

    // in_valid during BUSY is ignored
    a = {$urandom, $urandom, $urandom, $urandom};
    b = ~a;
    send(a);
    in_data = b; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    check("busy_ign_latency", lat + 2, 4);
    check("busy_ign_data", out_data, sub_ref(a));
    take();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("busy_ign_one_txn", seen, 0);

    // reset at the 2nd BUSY cycle
    send({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_no_valid", out_valid, 0);
    d = {$urandom, $urandom, $urandom, $urandom};
    send(d);
    wait_out(lat);
    check("after_rst_latency", lat, 4);
    check("after_rst_data", out_data, sub_ref(d));
    take();

    // parameter sweep with the B vector
    for (int g = 0; g < 4; g++) sw_lat[g] = 0;
    @(posedge clk); #1;
    check("sw_idle", 128'(sw_in_ready), 128'(4'hf));
    in_data  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    in_data  = '0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      for (int g = 0; g < 4; g++)
        if (sw_out_valid[g] && sw_lat[g] == 0) sw_lat[g] = n;
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sw%0d_latency", SW[g]), sw_lat[g], 16 / SW[g]);
      check($sformatf("sw%0d_data", SW[g]), sw_out_data[g],
            128'hd42711aee0bf98f1b8b45de51e415230);
    end
    sw_ready = 1'b1;
    @(posedge clk); #1;
    sw_ready = 1'b0;
    check("sw_released", 128'(sw_out_valid), 128'(0));

    // random blocks with random output stalls
    for (int t = 0; t < 1000; t++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      if (t % 7 == 0) d[127:96] = '0;
      send(d);
      wait_out(lat);
      check("rnd_latency", lat, 4);
      held = sub_ref(d);
      check("rnd_data", out_data, held);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check("rnd_stall_data", out_data, held);
      end
      take();
      check("rnd_drop", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
